// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous square
// wave in system-clock cycles, with a sticky timeout when the input stalls.
module period_meter #(
   parameter int unsigned     WIDTH       = 32,
   parameter longint unsigned TIMEOUT     = 100000000,
   parameter int unsigned     SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] high_time,
   output logic             period_valid,
   output logic             timeout,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_EDGE,
      MEASURE
   } state_t;

   localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

   state_t                 state;
   state_t                 state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sig_s;
   logic                   sig_d;
   logic                   rise;
   logic                   fall;
   logic [WIDTH-1:0]       cnt;
   logic [WIDTH-1:0]       hi_cnt;
   logic                   fell;
   logic                   cnt_expired;

   assign sig_s       = sync_q[SYNC_STAGES-1];
   assign rise        = sig_s & ~sig_d;
   assign fall        = ~sig_s & sig_d;
   assign cnt_expired = (cnt == TIMEOUT_CNT);

   // Synchroniser chain and previous-sample flop; free-running in every state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
         sig_d  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         sig_d  <= sig_s;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a rise always wins over an expiring counter
   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:      state_nxt = WAIT_EDGE;
            WAIT_EDGE: if (rise) state_nxt = MEASURE;
            MEASURE:   if (!rise && cnt_expired) state_nxt = WAIT_EDGE;
            default:   state_nxt = IDLE;
         endcase
      end
   end

   // Counters, measurement results, valid strobe and sticky timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt          <= '0;
         hi_cnt       <= '0;
         fell         <= 1'b0;
         period       <= '0;
         high_time    <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (!enable) begin
            cnt     <= '0;
            hi_cnt  <= '0;
            fell    <= 1'b0;
            timeout <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  cnt    <= '0;
                  hi_cnt <= '0;
                  fell   <= 1'b0;
               end
               WAIT_EDGE: begin
                  if (rise) begin
                     cnt    <= WIDTH'(1);
                     hi_cnt <= WIDTH'(1);
                     fell   <= 1'b0;
                  end else if (cnt_expired) begin
                     timeout <= 1'b1;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt + WIDTH'(1);
                  end
               end
               MEASURE: begin
                  if (rise) begin
                     period       <= cnt;
                     high_time    <= hi_cnt;
                     period_valid <= 1'b1;
                     timeout      <= 1'b0;
                     cnt          <= WIDTH'(1);
                     hi_cnt       <= WIDTH'(1);
                     fell         <= 1'b0;
                  end else if (cnt_expired) begin
                     timeout <= 1'b1;
                     cnt     <= '0;
                     hi_cnt  <= '0;
                     fell    <= 1'b0;
                  end else begin
                     cnt <= cnt + WIDTH'(1);
                     if (fall) begin
                        fell <= 1'b1;
                     end else if (sig_s && !fell) begin
                        hi_cnt <= hi_cnt + WIDTH'(1);
                     end
                  end
               end
               default: begin
                  cnt    <= '0;
                  hi_cnt <= '0;
                  fell   <= 1'b0;
               end
            endcase
         end
      end
   end

   // Busy output decoded from the registered state
   always_comb begin
      busy = (state != IDLE);
   end

endmodule
